// File: rtl/vadd_launch_ctrl.sv
// vadd_launch_ctrl: runs one vadd kernel launch per job over AXI4-Lite.
// It writes the arguments, sets ap_start, then polls ap_done with a timeout.
module vadd_launch_ctrl #(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int POLL_GAP                   = 16,
    parameter int MAX_POLLS                  = 65535
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst,
    input  logic                                  job_valid,
    output logic                                  job_ready,
    input  logic [63:0]                           job_a,
    input  logic [63:0]                           job_b,
    input  logic [63:0]                           job_c,
    input  logic [31:0]                           job_len,
    output logic                                  done_valid,
    input  logic                                  done_ready,
    output logic [1:0]                            done_status,
    output logic                                  busy,
    output logic                                  m_awvalid,
    input  logic                                  m_awready,
    output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] m_awaddr,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]                            m_wstrb,
    input  logic                                  m_bvalid,
    output logic                                  m_bready,
    input  logic [1:0]                            m_bresp,
    output logic                                  m_arvalid,
    input  logic                                  m_arready,
    output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] m_araddr,
    input  logic                                  m_rvalid,
    output logic                                  m_rready,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                            m_rresp
);
    localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam int DW = C_S_AXI_CONTROL_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_POLL_AR,
        S_POLL_R,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [63:0] c_q;
    logic [31:0] len_q;
    logic [31:0] poll_cnt;
    logic [31:0] gap_cnt;
    logic        aw_left;
    logic        w_left;
    logic        unused_rdata;

    // Control register map of the vadd kernel, in write order.
    function automatic logic [7:0] reg_off(input logic [2:0] i);
        case (i)
            3'd0: reg_off = 8'h10;
            3'd1: reg_off = 8'h14;
            3'd2: reg_off = 8'h1C;
            3'd3: reg_off = 8'h20;
            3'd4: reg_off = 8'h28;
            3'd5: reg_off = 8'h2C;
            3'd6: reg_off = 8'h34;
            3'd7: reg_off = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] reg_val(
        input logic [2:0]  i,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] c,
        input logic [31:0] len
    );
        case (i)
            3'd0: reg_val = a[31:0];
            3'd1: reg_val = a[63:32];
            3'd2: reg_val = b[31:0];
            3'd3: reg_val = b[63:32];
            3'd4: reg_val = c[31:0];
            3'd5: reg_val = c[63:32];
            3'd6: reg_val = len;
            3'd7: reg_val = 32'h1;
        endcase
    endfunction

    assign aw_left      = m_awvalid && !m_awready;
    assign w_left       = m_wvalid && !m_wready;
    assign job_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign m_bready     = (state == S_WRESP);
    assign m_rready     = (state == S_POLL_R);
    assign m_wstrb      = 4'hF;
    assign m_araddr     = '0;
    assign unused_rdata = ^{m_rdata[DW-1:2], m_rdata[0]};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            len_q       <= '0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_awaddr    <= '0;
            m_wdata     <= '0;
            done_valid  <= 1'b0;
            done_status <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        a_q      <= job_a;
                        b_q      <= job_b;
                        c_q      <= job_c;
                        len_q    <= job_len;
                        idx      <= '0;
                        poll_cnt <= '0;
                        if (job_len == '0) begin
                            state       <= S_DONE;
                            done_status <= 2'b11;
                        end else begin
                            state     <= S_WRITE;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            m_awaddr  <= AW'(reg_off(3'd0));
                            m_wdata   <= DW'(reg_val(3'd0, job_a, job_b,
                                                     job_c, job_len));
                        end
                    end
                end
                S_WRITE: begin
                    if (m_awready) m_awvalid <= 1'b0;
                    if (m_wready) m_wvalid <= 1'b0;
                    if (!aw_left && !w_left) state <= S_WRESP;
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00) begin
                            state       <= S_DONE;
                            done_status <= 2'b10;
                        end else if (idx == 3'd7) begin
                            state     <= S_POLL_AR;
                            m_arvalid <= 1'b1;
                        end else begin
                            idx       <= idx + 3'd1;
                            state     <= S_WRITE;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            m_awaddr  <= AW'(reg_off(idx + 3'd1));
                            m_wdata   <= DW'(reg_val(idx + 3'd1, a_q, b_q,
                                                     c_q, len_q));
                        end
                    end
                end
                S_POLL_AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        poll_cnt  <= poll_cnt + 32'd1;
                        state     <= S_POLL_R;
                    end
                end
                S_POLL_R: begin
                    if (m_rvalid) begin
                        if (m_rresp != 2'b00) begin
                            state       <= S_DONE;
                            done_status <= 2'b10;
                        end else if (m_rdata[1]) begin
                            state       <= S_DONE;
                            done_status <= 2'b00;
                        end else if (poll_cnt == 32'(MAX_POLLS)) begin
                            state       <= S_DONE;
                            done_status <= 2'b01;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 32'(POLL_GAP - 1)) begin
                        state     <= S_POLL_AR;
                        m_arvalid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    // done_valid rises one cycle after entering DONE
                    if (!done_valid) begin
                        done_valid <= 1'b1;
                    end else if (done_ready) begin
                        done_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vadd_launch_ctrl.sv
// tb_vadd_launch_ctrl: directed and random jobs against an event-level model;
// a monitor pops expected writes, reads and completions from a queue.
`timescale 1ns/1ps
module tb_vadd_launch_ctrl;
    localparam int AW = 12;
    localparam int G  = 5;
    localparam int MP = 4;

    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_DN = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [63:0]   job_a = '0;
    logic [63:0]   job_b = '0;
    logic [63:0]   job_c = '0;
    logic [31:0]   job_len = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [1:0]    done_status;
    logic          busy;
    logic          m_awvalid;
    logic          m_awready = 1'b0;
    logic [AW-1:0] m_awaddr;
    logic          m_wvalid;
    logic          m_wready = 1'b0;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_bvalid = 1'b0;
    logic          m_bready;
    logic [1:0]    m_bresp = '0;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [AW-1:0] m_araddr;
    logic          m_rvalid = 1'b0;
    logic          m_rready;
    logic [31:0]   m_rdata = '0;
    logic [1:0]    m_rresp = '0;

    always #5 clk = ~clk;

    vadd_launch_ctrl #(
        .C_S_AXI_CONTROL_ADDR_WIDTH(AW),
        .C_S_AXI_CONTROL_DATA_WIDTH(32),
        .POLL_GAP(G),
        .MAX_POLLS(MP)
    ) dut (
        .ap_clk(clk), .ap_rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_len(job_len),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_status(done_status), .busy(busy),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  last_rd = 0;
    bit  stall = 0;
    int  err_at = 0;
    int  done_at = 0;
    int  rerr_at = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [1:0] k, input logic [31:0] ad,
                                 input logic [31:0] dt, input int gp);
        ev_t e;
        e.kind = k;
        e.addr = ad;
        e.data = dt;
        e.gap  = gp;
        sb.push_back(e);
    endfunction

    // Expected bus events of one job, derived from the register map and
    // the slave scenario knobs (error write, error poll, ap_done poll).
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] c, input logic [31:0] len);
        logic [7:0]  offs [8];
        logic [31:0] vals [8];
        offs = '{8'h10, 8'h14, 8'h1C, 8'h20, 8'h28, 8'h2C, 8'h34, 8'h00};
        vals = '{a[31:0], a[63:32], b[31:0], b[63:32],
                 c[31:0], c[63:32], len, 32'h1};
        if (len == 32'd0) begin
            push(K_DN, 32'd0, 32'd3, -1);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            push(K_WR, {24'h0, offs[i]}, vals[i], -1);
            if (i + 1 == err_at) begin
                push(K_DN, 32'd0, 32'd2, -1);
                return;
            end
        end
        for (int p = 1; p <= MP; p++) begin
            push(K_RD, 32'd0, 32'd0, (p > 1 && !stall) ? G + 2 : -1);
            if (p == rerr_at) begin
                push(K_DN, 32'd0, 32'd2, -1);
                return;
            end
            if (p == done_at) begin
                push(K_DN, 32'd0, 32'd0, -1);
                return;
            end
        end
        push(K_DN, 32'd0, 32'd1, -1);
    endfunction

    function automatic void take(input logic [1:0] k, input logic [31:0] ad,
                                 input logic [31:0] dt);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_event: got kind %0d addr 0x%0h data 0x%0h want none",
                     k, ad, dt);
            return;
        end
        e = sb.pop_front();
        check("ev_kind", 64'(k), 64'(e.kind));
        check("ev_addr", 64'(ad), 64'(e.addr));
        if (k != K_RD) check("ev_data", 64'(dt), 64'(e.data));
        if (k == K_RD && e.gap >= 0)
            check("rd_gap", 64'(cyc - last_rd), 64'(e.gap));
    endfunction

    // AXI4-Lite slave: random ready stalls and delayed responses
    initial begin : slave
        logic hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_job;
        logic got_aw, got_w, b_pend, r_pend;
        int   b_wait, r_wait, wr_n, poll_n;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        b_wait = 0; r_wait = 0; wr_n = 0; poll_n = 0;
        forever begin
            @(negedge clk);
            hs_aw  = m_awvalid && m_awready;
            hs_w   = m_wvalid && m_wready;
            hs_b   = m_bvalid && m_bready;
            hs_ar  = m_arvalid && m_arready;
            hs_r   = m_rvalid && m_rready;
            hs_job = job_valid && job_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
                m_bvalid = 0; m_rvalid = 0;
                m_awready = 0; m_wready = 0; m_arready = 0;
                done_ready = 0;
            end else begin
                if (hs_job) begin
                    wr_n = 0;
                    poll_n = 0;
                end
                if (hs_aw) got_aw = 1;
                if (hs_w) got_w = 1;
                if (hs_b) begin
                    m_bvalid = 0;
                    b_pend = 0;
                end
                if (got_aw && got_w) begin
                    got_aw = 0;
                    got_w = 0;
                    wr_n++;
                    b_pend = 1;
                    b_wait = stall ? int'($urandom_range(0, 3)) : 0;
                    m_bresp = (wr_n == err_at) ? 2'b10 : 2'b00;
                end
                if (b_pend && !m_bvalid) begin
                    if (b_wait == 0) m_bvalid = 1;
                    else b_wait--;
                end
                if (hs_r) begin
                    m_rvalid = 0;
                    r_pend = 0;
                end
                if (hs_ar) begin
                    poll_n++;
                    r_pend = 1;
                    r_wait = stall ? int'($urandom_range(0, 3)) : 0;
                    m_rresp = (poll_n == rerr_at) ? 2'b10 : 2'b00;
                    m_rdata = $urandom;
                    m_rdata[1] = (poll_n == done_at);
                end
                if (r_pend && !m_rvalid) begin
                    if (r_wait == 0) m_rvalid = 1;
                    else r_wait--;
                end
                m_awready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                m_wready   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                m_arready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                done_ready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pairs AW/W into write events, checks holds and exclusivity
    initial begin : monitor
        logic [31:0]   w_addr, w_data;
        bit            have_aw, have_w, p_aw, p_w, p_ar, p_dn, chk_idle;
        logic [AW-1:0] p_awaddr;
        logic [31:0]   p_wdata;
        logic [1:0]    p_st;
        have_aw = 0; have_w = 0; p_aw = 0; p_w = 0; p_ar = 0; p_dn = 0;
        chk_idle = 0; w_addr = 0; w_data = 0; p_awaddr = 0; p_wdata = 0;
        p_st = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outputs", 64'({m_awvalid, m_wvalid, m_arvalid,
                      m_bready, m_rready, done_valid, busy, done_status}),
                      64'(0));
                have_aw = 0; have_w = 0; p_aw = 0; p_w = 0; p_ar = 0;
                p_dn = 0; chk_idle = 0;
                continue;
            end
            if (p_aw) check("aw_hold", 64'({m_awvalid, m_awaddr}),
                            64'({1'b1, p_awaddr}));
            if (p_w) check("w_hold", 64'({m_wvalid, m_wdata}),
                           64'({1'b1, p_wdata}));
            if (p_ar) check("ar_hold", 64'(m_arvalid), 64'(1));
            if (p_dn) check("done_hold", 64'({done_valid, done_status}),
                            64'({1'b1, p_st}));
            if (chk_idle) begin
                check("idle_after_done", 64'({busy, job_ready}), 64'(2'b01));
                chk_idle = 0;
            end
            if (m_arvalid)
                check("ar_exclusive", 64'({m_awvalid, m_wvalid, m_bready}),
                      64'(0));
            if (m_awvalid && m_awready) begin
                have_aw = 1;
                w_addr = 32'(m_awaddr);
            end
            if (m_wvalid && m_wready) begin
                have_w = 1;
                w_data = m_wdata;
                check("wstrb", 64'(m_wstrb), 64'(4'hF));
            end
            if (have_aw && have_w) begin
                have_aw = 0;
                have_w = 0;
                take(K_WR, w_addr, w_data);
            end
            if (m_arvalid && m_arready) begin
                take(K_RD, 32'(m_araddr), 32'd0);
                last_rd = cyc;
            end
            if (done_valid && done_ready) begin
                take(K_DN, 32'd0, {30'd0, done_status});
                chk_idle = 1;
            end
            p_aw     = m_awvalid && !m_awready;
            p_awaddr = m_awaddr;
            p_w      = m_wvalid && !m_wready;
            p_wdata  = m_wdata;
            p_ar     = m_arvalid && !m_arready;
            p_dn     = done_valid && !done_ready;
            p_st     = done_status;
        end
    end

    task automatic run_job(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [31:0] len);
        int n;
        model(a, b, c, len);
        @(posedge clk);
        #1;
        job_a = a;
        job_b = b;
        job_c = c;
        job_len = len;
        job_valid = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!job_ready && n < 50);
        check("job_accept", 64'(job_ready), 64'(1));
        @(posedge clk);
        #1;
        job_valid = 0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d events outstanding want 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic knobs(input bit s, input int e, input int d, input int r);
        stall = s;
        err_at = e;
        done_at = d;
        rerr_at = r;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_reset", 64'({job_ready, busy, m_awaddr, m_wdata, m_araddr}),
              64'({1'b1, 1'b0, 12'h0, 32'h0, 12'h0}));

        knobs(0, 0, 3, 0);
        run_job(64'h1_0000_0000, 64'h2000, 64'h3000, 32'd1024);
        job_valid = 1;
        job_len = 0;
        repeat (4) begin
            @(negedge clk);
            check("busy_no_accept", 64'({job_ready, busy}), 64'(2'b01));
        end
        @(posedge clk);
        #1;
        job_valid = 0;
        drain("basic_job");

        knobs(0, 0, 3, 0);
        run_job(64'h55, 64'h66, 64'h77, 32'd0);
        @(negedge clk);
        check("zero_len_c1", 64'({done_valid, busy}), 64'(2'b01));
        @(negedge clk);
        check("zero_len_c2", 64'({done_valid, done_status}), 64'(3'b111));
        drain("zero_len");

        knobs(0, 3, 3, 0);
        run_job(64'hDEAD_BEEF_0000_1000, 64'h4000, 64'h5000, 32'd16);
        drain("bresp_err");

        knobs(0, 0, 0, 0);
        run_job(64'h10, 64'h20, 64'h30, 32'd7);
        drain("timeout");

        knobs(1, 0, 3, 0);
        run_job(64'h1_0000_0000, 64'h2000, 64'h3000, 32'd1024);
        drain("stall_basic");

        for (int i = 0; i < 10; i++) begin
            knobs(1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0,
                  int'($urandom_range(0, MP)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, MP)) : 0);
            run_job({$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom},
                    ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom));
            drain("random_job");
        end

        knobs(0, 0, 3, 0);
        run_job(64'hAAAA, 64'hBBBB, 64'hCCCC, 32'd9);
        n = 0;
        while (!m_bready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wresp", 64'(m_bready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_abort", 64'({job_ready, busy, done_valid, m_awaddr, m_wdata}),
              64'({1'b1, 1'b0, 1'b0, 12'h0, 32'h0}));
        run_job(64'h1234_5678_9ABC_DEF0, 64'h2000, 64'h3000, 32'd64);
        drain("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
